// File: rtl/z3_slave_pkg.sv
// Shared types and helpers for the Zorro III slave window controller.
// State encoding, default widths and the per-window match helper live here.
package z3_slave_pkg;

  localparam int Z3_DEC_W  = 6;
  localparam int Z3_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } z3_state_t;

  // A window hits when every care bit of the offset equals its match bit.
  function automatic logic win_hit(input logic [31:0] a,
                                   input logic [31:0] m,
                                   input logic [31:0] k);
    return ((a ^ m) & k) == 32'd0;
  endfunction

endpackage

// File: rtl/z3_win_decode.sv
// Combinational window decoder: compares the offset bits against every
// window's match/mask pair and keeps only the lowest-index hit (one-hot).
module z3_win_decode
  import z3_slave_pkg::*;
#(
  parameter int                         NUM_WIN   = 4,
  parameter int                         DEC_W     = Z3_DEC_W,
  parameter logic [NUM_WIN*DEC_W-1:0]   WIN_MATCH = '0,
  parameter logic [NUM_WIN*DEC_W-1:0]   WIN_MASK  = '0
)(
  input  logic [DEC_W-1:0]   addr,
  output logic [NUM_WIN-1:0] hit,
  output logic               hit_any
);

  logic [NUM_WIN-1:0] raw;

  // Per-window compare of the offset bits against each match/mask pair.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      raw[i] = win_hit(32'(addr),
                       32'(WIN_MATCH[i*DEC_W +: DEC_W]),
                       32'(WIN_MASK[i*DEC_W +: DEC_W]));
    end
  end

  // Lowest set bit of the raw hits gives the winning window.
  assign hit     = raw & (~raw + NUM_WIN'(1));
  assign hit_any = |raw;

endmodule

// File: rtl/z3_slave_window_ctrl.sv
// Zorro III slave-cycle controller: decodes card accesses into NUM_WIN
// windows and runs each cycle IDLE -> WAIT -> ACK -> IDLE, producing the
// one-hot window select, a start pulse, SLAVE and DTACK.
// Optional feature macro: Z3_SLAVE_TIMEOUT_EN (WAIT timeout with bus error,
// also terminating strobed card cycles that hit no window).
module z3_slave_window_ctrl
  import z3_slave_pkg::*;
#(
  parameter int                          NUM_WIN   = 4,
  parameter int                          DEC_W     = Z3_DEC_W,
  parameter logic [NUM_WIN*DEC_W-1:0]    WIN_MATCH = 24'h800400,
  parameter logic [NUM_WIN*DEC_W-1:0]    WIN_MASK  = 24'hE30C3C,
  parameter int                          WAIT_W    = Z3_WAIT_W,
  parameter logic [NUM_WIN*WAIT_W-1:0]   WIN_WAIT  = 16'h1300,
  parameter logic [NUM_WIN-1:0]          WIN_EXT   = 4'b0010,
  parameter int                          TO_CYC    = 64
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               card_cycle,
  input  logic               fcs_n,
  input  logic               doe,
  input  logic [3:0]         ds_n,
  input  logic               read,
  input  logic [DEC_W-1:0]   addr,
  input  logic [NUM_WIN-1:0] ext_ack,
  output logic [NUM_WIN-1:0] win_sel,
  output logic               win_start,
  output logic               slave,
  output logic               dtack,
  output logic               busy,
  output logic               berr
);

  z3_state_t          state, state_nxt;
  logic [NUM_WIN-1:0] hit, win_sel_nxt;
  logic               hit_any, strobe, accept, timeout_hit;
  logic               has_win, ext_mode, ext_hit;
  logic               win_start_nxt, dtack_nxt, berr_nxt;
  logic [WAIT_W-1:0]  cnt, cnt_nxt, wait_load;
  logic               unused_read;

  // Direction is qualified downstream through win_sel; sequencing ignores it.
  assign unused_read = read;

  z3_win_decode #(
    .NUM_WIN   (NUM_WIN),
    .DEC_W     (DEC_W),
    .WIN_MATCH (WIN_MATCH),
    .WIN_MASK  (WIN_MASK)
  ) u_decode (
    .addr    (addr),
    .hit     (hit),
    .hit_any (hit_any)
  );

  assign slave    = card_cycle & ~fcs_n;
  assign strobe   = ~fcs_n & card_cycle & doe & (ds_n != 4'hF);
  assign has_win  = |win_sel;
  assign ext_mode = |(win_sel & WIN_EXT);
  assign ext_hit  = |(win_sel & ext_ack);

`ifdef Z3_SLAVE_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Any qualified strobe is taken so the timeout can terminate unmatched cycles.
  assign accept      = 1'b1;
  assign timeout_hit = (state == WAIT) && (to_cnt == TO_W'(TO_CYC - 1));

  // Clocks elapsed since the strobe was sampled; bounds how long WAIT may stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if ((state == IDLE) && (state_nxt == WAIT)) begin
      to_cnt <= TO_W'(1);
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`else
  localparam int unused_to_cyc = TO_CYC;

  assign accept      = hit_any;
  assign timeout_hit = 1'b0;
`endif

  // Wait-state preload taken from the window that is about to be entered.
  always_comb begin
    wait_load = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      wait_load = wait_load | (WIN_WAIT[i*WAIT_W +: WAIT_W] & {WAIT_W{hit[i]}});
    end
  end

  // Next-state and next-output decision for the slave cycle sequencer.
  always_comb begin
    state_nxt     = state;
    win_sel_nxt   = win_sel;
    win_start_nxt = 1'b0;
    dtack_nxt     = dtack;
    berr_nxt      = berr;
    cnt_nxt       = cnt;
    case (state)
      IDLE: begin
        dtack_nxt = 1'b0;
        berr_nxt  = 1'b0;
        if (strobe && accept) begin
          state_nxt     = WAIT;
          win_sel_nxt   = hit;
          win_start_nxt = 1'b1;
          cnt_nxt       = wait_load;
        end else begin
          win_sel_nxt = '0;
          cnt_nxt     = '0;
        end
      end
      WAIT: begin
        if (fcs_n) begin
          // Master gave up the cycle: leave quietly, no DTACK, no BERR.
          state_nxt   = IDLE;
          win_sel_nxt = '0;
          cnt_nxt     = '0;
        end else if (timeout_hit) begin
          state_nxt = ACK;
          dtack_nxt = 1'b1;
          berr_nxt  = 1'b1;
        end else if (has_win && ext_mode) begin
          if (ext_hit) begin
            state_nxt = ACK;
            dtack_nxt = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end else if (has_win && (cnt == '0)) begin
          state_nxt = ACK;
          dtack_nxt = 1'b1;
        end else if (has_win) begin
          cnt_nxt = cnt - WAIT_W'(1);
        end else begin
          state_nxt = WAIT;
        end
      end
      ACK: begin
        if (fcs_n) begin
          state_nxt   = IDLE;
          win_sel_nxt = '0;
          dtack_nxt   = 1'b0;
          berr_nxt    = 1'b0;
          cnt_nxt     = '0;
        end else begin
          state_nxt = ACK;
        end
      end
      default: begin
        state_nxt   = IDLE;
        win_sel_nxt = '0;
        dtack_nxt   = 1'b0;
        berr_nxt    = 1'b0;
        cnt_nxt     = '0;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win_sel   <= '0;
      win_start <= 1'b0;
      dtack     <= 1'b0;
      berr      <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      win_sel   <= win_sel_nxt;
      win_start <= win_start_nxt;
      dtack     <= dtack_nxt;
      berr      <= berr_nxt;
      busy      <= (state_nxt != IDLE);
      cnt       <= cnt_nxt;
    end
  end

endmodule
